// File: rtl/npc_pkg.sv
// Shared NPC types: operand-select encodings, ALU control codes and the
// issue-entry record carried from the operand-issue stage to the ALU.
package npc_pkg;

  // Datapath width the issue-entry struct is built for; alu_issue's XLEN must match.
  localparam int NPC_XLEN = 32;

  typedef enum logic {
    A_SEL_RS1 = 1'b0,
    A_SEL_PC  = 1'b1
  } a_sel_e;

  typedef enum logic [1:0] {
    B_SEL_RS2  = 2'b00,
    B_SEL_IMM  = 2'b01,
    B_SEL_FOUR = 2'b10,
    B_SEL_ZERO = 2'b11
  } b_sel_e;

  localparam logic [3:0] ALU_CTR_ADD  = 4'b0000;
  localparam logic [3:0] ALU_CTR_SLL  = 4'b0001;
  localparam logic [3:0] ALU_CTR_SLT  = 4'b0010;
  localparam logic [3:0] ALU_CTR_SLTU = 4'b0011;
  localparam logic [3:0] ALU_CTR_XOR  = 4'b0100;
  localparam logic [3:0] ALU_CTR_SRL  = 4'b0101;
  localparam logic [3:0] ALU_CTR_OR   = 4'b0110;
  localparam logic [3:0] ALU_CTR_AND  = 4'b0111;
  localparam logic [3:0] ALU_CTR_SUB  = 4'b1000;
  localparam logic [3:0] ALU_CTR_SRA  = 4'b1101;
  localparam logic [3:0] ALU_CTR_B    = 4'b1111;

  // Occupancy of the two-entry skid buffer, encoded as {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b10,
    OCC_FULL  = 2'b11
  } occ_e;

  typedef struct packed {
    logic [NPC_XLEN-1:0] a;
    logic [NPC_XLEN-1:0] b;
    logic [3:0]          ctr;
    logic [4:0]          rd;
    logic                rf_wen;
  } issue_entry_t;

endpackage

// File: rtl/alu_opnd_sel.sv
// Combinational ALU operand mux with optional writeback forwarding.
// Forwarding is compiled in with `define NPC_ALU_FWD_EN.
module alu_opnd_sel
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            a_sel,
  input  logic [1:0]      b_sel,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef NPC_ALU_FWD_EN
  // x0 is hardwired to zero, so a writeback tagged rd=0 must never win.
  assign rs1_val = (wb_valid && wb_rd == rs1_idx && rs1_idx != 5'd0) ? wb_data : rs1_data;
  assign rs2_val = (wb_valid && wb_rd == rs2_idx && rs2_idx != 5'd0) ? wb_data : rs2_data;
`else
  assign rs1_val = rs1_data;
  assign rs2_val = rs2_data;

  logic unused_fwd;
  assign unused_fwd = ^{rs1_idx, rs2_idx, wb_valid, wb_rd, wb_data};
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    a = rs1_val;
    b = '0;
    if (a_sel_e'(a_sel) == A_SEL_PC) a = pc;
    case (b_sel_e'(b_sel))
      B_SEL_RS2:  b = rs2_val;
      B_SEL_IMM:  b = imm;
      B_SEL_FOUR: b = XLEN'(4);
      B_SEL_ZERO: b = '0;
      default:    b = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage ahead of the ALU: operand select at capture, 2-entry skid
// buffer, registered in_ready. Optional forwarding: `define NPC_ALU_FWD_EN.
module alu_issue
  import npc_pkg::*;
#(
  parameter int XLEN = NPC_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_a_sel,
  input  logic [1:0]      in_b_sel,
  input  logic [3:0]      in_alu_ctr,
  input  logic [4:0]      in_rd,
  input  logic            in_rf_wen,
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rs2_idx,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctr,
  output logic [4:0]      out_rd,
  output logic            out_rf_wen
);

  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  issue_entry_t    cap_entry;
  issue_entry_t    main_q;
  issue_entry_t    skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic            do_in;
  logic            do_out;

  alu_opnd_sel #(.XLEN(XLEN)) u_opnd_sel (
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .pc       (in_pc),
    .imm      (in_imm),
    .a_sel    (in_a_sel),
    .b_sel    (in_b_sel),
    .rs1_idx  (in_rs1_idx),
    .rs2_idx  (in_rs2_idx),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .a        (sel_a),
    .b        (sel_b)
  );

  // Entries store the already-selected operands, never the raw fields.
  assign cap_entry = '{a: sel_a, b: sel_b, ctr: in_alu_ctr, rd: in_rd, rf_wen: in_rf_wen};

  assign do_in  = in_valid && in_ready;
  assign do_out = main_valid && out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too because they drive the outputs directly.
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (occ_e'({main_valid, skid_valid}))
        OCC_EMPTY: begin
          if (do_in) begin
            main_q     <= cap_entry;
            main_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (do_in && !do_out) begin
            skid_q     <= cap_entry;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
          end else if (!do_in && do_out) begin
            main_valid <= 1'b0;
          end else if (do_in && do_out) begin
            main_q <= cap_entry;
          end
        end
        OCC_FULL: begin
          if (do_out) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          // Skid-only is unreachable; fall back to empty rather than emit a bubble entry.
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid  = main_valid;
  assign alu_a      = main_q.a;
  assign alu_b      = main_q.b;
  assign alu_ctr    = main_q.ctr;
  assign out_rd     = main_q.rd;
  assign out_rf_wen = main_q.rf_wen;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: reset, operand select, skid
// back-pressure ordering, streaming throughput, forwarding, reset while full.
module tb_alu_issue;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
  logic            in_a_sel;
  logic [1:0]      in_b_sel;
  logic [3:0]      in_alu_ctr;
  logic [4:0]      in_rd;
  logic            in_rf_wen;
  logic [4:0]      in_rs1_idx, in_rs2_idx;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [3:0]      alu_ctr;
  logic [4:0]      out_rd;
  logic            out_rf_wen;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_pc       (in_pc),
    .in_imm      (in_imm),
    .in_a_sel    (in_a_sel),
    .in_b_sel    (in_b_sel),
    .in_alu_ctr  (in_alu_ctr),
    .in_rd       (in_rd),
    .in_rf_wen   (in_rf_wen),
    .in_rs1_idx  (in_rs1_idx),
    .in_rs2_idx  (in_rs2_idx),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctr     (alu_ctr),
    .out_rd      (out_rd),
    .out_rf_wen  (out_rf_wen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic a_sel, input logic [1:0] b_sel,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [3:0] ctr, input logic [4:0] rd);
    in_valid    = v;
    in_a_sel    = a_sel;
    in_b_sel    = b_sel;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_pc       = pc;
    in_imm      = imm;
    in_alu_ctr  = ctr;
    in_rd       = rd;
    in_rf_wen   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_rs1_idx = '0; in_rs2_idx = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 4'h0, 5'd0);
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_alu_a",     alu_a,          32'd0);
    check("rst_alu_b",     alu_b,          32'd0);
    check("rst_alu_ctr",   32'(alu_ctr),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // rs1 + imm
    drive(1'b1, 1'b0, 2'b01, 32'd5, 32'd99, 32'h100, 32'd7, 4'b0000, 5'd1);
    tick();
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 4'h0, 5'd0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_a",     alu_a,          32'd5);
    check("t1_b",     alu_b,          32'd7);
    check("t1_ctr",   32'(alu_ctr),   32'h0);
    check("t1_rd",    32'(out_rd),    32'd1);
    tick();
    check("t1_drained", 32'(out_valid), 32'd0);

    // pc + 4 (jal link), rs2 pass-through, zero constant
    drive(1'b1, 1'b1, 2'b10, 32'h1234, 32'd9, 32'h8000_0000, 32'd3, 4'b0000, 5'd2);
    tick();
    check("jal_a", alu_a, 32'h8000_0000);
    check("jal_b", alu_b, 32'd4);
    drive(1'b1, 1'b0, 2'b00, 32'h10, 32'hdead, 32'h0, 32'd3, 4'b1101, 5'd3);
    tick();
    check("rs2_a",   alu_a,        32'h10);
    check("rs2_b",   alu_b,        32'hdead);
    check("rs2_ctr", 32'(alu_ctr), 32'hd);
    drive(1'b1, 1'b0, 2'b11, 32'h20, 32'hbeef, 32'h0, 32'd3, 4'b1111, 5'd4);
    tick();
    check("zero_b", alu_b, 32'd0);
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 4'h0, 5'd0);
    tick();
    check("zero_drained", 32'(out_valid), 32'd0);

    // back-pressure: 2 accepted, third held, then FIFO drain
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 32'd101, 0, 0, 0, 4'h1, 5'd11);
    tick();
    check("bp_ready1", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 2'b11, 32'd102, 0, 0, 0, 4'h2, 5'd12);
    tick();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_main_a",     alu_a,         32'd101);
    drive(1'b1, 1'b0, 2'b11, 32'd103, 0, 0, 0, 4'h3, 5'd13);
    tick();
    tick();
    check("bp_hold_ready", 32'(in_ready),  32'd0);
    check("bp_hold_a",     alu_a,          32'd101);
    check("bp_hold_rd",    32'(out_rd),    32'd11);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_out2_a",  alu_a,         32'd102);
    check("bp_out2_rd", 32'(out_rd),   32'd12);
    check("bp_ready_up", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 4'h0, 5'd0);
    check("bp_out3_a",   alu_a,          32'd103);
    check("bp_out3_ctr", 32'(alu_ctr),   32'h3);
    check("bp_out3_v",   32'(out_valid), 32'd1);
    tick();
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // streaming: 8 back-to-back with out_ready high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 2'b01, 32'(200 + i), 0, 0, 32'(3 * i), 4'(i), 5'(i));
      tick();
      check($sformatf("stream_a%0d", i), alu_a, 32'(200 + i));
      check($sformatf("stream_b%0d", i), alu_b, 32'(3 * i));
      check($sformatf("stream_rdy%0d", i), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 4'h0, 5'd0);
    tick();
    check("stream_end", 32'(out_valid), 32'd0);

    // forwarding on rs1 (raw operand expected when compiled out)
    in_rs1_idx = 5'd3; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    drive(1'b1, 1'b0, 2'b11, 32'h11, 0, 0, 0, 4'h0, 5'd5);
    tick();
`ifdef NPC_ALU_FWD_EN
    check("fwd_rs1", alu_a, 32'h55);
`else
    check("fwd_rs1", alu_a, 32'h11);
`endif
    in_rs1_idx = 5'd0; wb_rd = 5'd0;
    tick();
    check("fwd_x0", alu_a, 32'h11);
    wb_valid = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 4'h0, 5'd0);
    tick();

    // reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 32'hA1, 0, 0, 0, 4'h1, 5'd1);
    tick();
    drive(1'b1, 1'b0, 2'b11, 32'hA2, 0, 0, 0, 4'h2, 5'd2);
    tick();
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 4'h0, 5'd0);
    check("rf_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rf_valid", 32'(out_valid), 32'd0);
    check("rf_ready", 32'(in_ready),  32'd1);
    check("rf_a",     alu_a,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b11, 32'h77, 0, 0, 0, 4'h7, 5'd7);
    tick();
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 4'h0, 5'd0);
    check("rf_new_a", alu_a,          32'h77);
    check("rf_new_v", 32'(out_valid), 32'd1);
    tick();
    check("rf_no_stale", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
